// File: rtl/bp_common_pkg.sv
// Shared BlackParrot types: commit record layout and
// the bit positions of the commit-matcher error vector.
package bp_common_pkg;

   localparam int bp_err_commit_overflow_gp = 0;
   localparam int bp_err_rf_overflow_gp     = 1;
   localparam int bp_err_timeout_gp         = 2;
   localparam int bp_err_collision_gp       = 3;

   localparam int bp_commit_pc_max_gp = 64;
   localparam int bp_commit_rd_max_gp = 8;

   // Fields are sized for the widest configuration; users truncate.
   typedef struct packed {
      logic [bp_commit_pc_max_gp-1:0] pc;
      logic [31:0]                    instr;
      logic                           rd_w_v;
      logic [bp_commit_rd_max_gp-1:0] rd_addr;
      logic                           trap;
   } bp_commit_rec_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO; an enqueue into a full FIFO is
// accepted when the head is being dequeued in the same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w = $clog2(els_p + 1);

   logic [width_p-1:0] mem [els_p];
   logic [ptr_w-1:0]   rptr, wptr;
   logic [cnt_w-1:0]   cnt;
   logic               full, enq, deq;

   function automatic logic [ptr_w-1:0] ptr_inc(logic [ptr_w-1:0] p);
      return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt == cnt_w'(els_p));
   assign ready_o = ~full;
   assign v_o     = (cnt != '0);
   assign deq     = yumi_i & v_o;
   assign enq     = v_i & (~full | deq);
   assign data_o  = mem[rptr];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (enq) wptr <= ptr_inc(wptr);
         if (deq) rptr <= ptr_inc(rptr);
         unique case ({enq, deq})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr] <= data_i;
   end

endmodule

// File: rtl/bp_nonsynth_commit_matcher.sv
// Pairs in-order commit records with out-of-order register
// writebacks and streams matched records with their data.
module bp_nonsynth_commit_matcher
   import bp_common_pkg::*;
#(
   parameter int vaddr_width_p = 39,
   parameter int data_width_p  = 64,
   parameter int rf_els_p      = 64,
   parameter int num_wb_p      = 2,
   parameter int commit_els_p  = 16,
   parameter int rf_els_fifo_p = 8,
   parameter int timeout_p     = 1024,
   localparam int rf_addr_w    = $clog2(rf_els_p)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             commit_v_i,
   input  logic [vaddr_width_p-1:0]         commit_pc_i,
   input  logic [31:0]                      commit_instr_i,
   input  logic                             commit_rd_w_v_i,
   input  logic [rf_addr_w-1:0]             commit_rd_addr_i,
   input  logic                             commit_trap_i,
   input  logic [num_wb_p-1:0]              wb_v_i,
   input  logic [num_wb_p*rf_addr_w-1:0]    wb_addr_i,
   input  logic [num_wb_p*data_width_p-1:0] wb_data_i,
   output logic                             match_v_o,
   input  logic                             match_yumi_i,
   output logic [vaddr_width_p-1:0]         match_pc_o,
   output logic [31:0]                      match_instr_o,
   output logic                             match_rd_w_v_o,
   output logic                             match_trap_o,
   output logic [data_width_p-1:0]          match_data_o,
   output logic [63:0]                      instr_cnt_o,
   output logic [3:0]                       err_o
);

   localparam int stall_w = $clog2(timeout_p + 1);

   bp_commit_rec_s cm_rec, cm_head;
   logic           cm_enq_v, cm_ready, cm_v, deq;
   logic           unused_head;

   logic [rf_addr_w-1:0]    rd_sel;
   logic [rf_els_p-1:0]     rf_v, rf_ready, rf_head_v, rf_deq;
   logic [data_width_p-1:0] rf_d      [rf_els_p];
   logic [data_width_p-1:0] rf_head_d [rf_els_p];

   logic               collision;
   logic [stall_w-1:0] stall_cnt, stall_n;
   logic [3:0]         err_n;

   assign cm_rec = '{
      pc:      bp_commit_pc_max_gp'(commit_pc_i),
      instr:   commit_instr_i,
      rd_w_v:  commit_rd_w_v_i,
      rd_addr: bp_commit_rd_max_gp'(commit_rd_addr_i),
      trap:    commit_trap_i
   };
   assign cm_enq_v = commit_v_i & ~reset_i;

   bsg_fifo_1r1w_small #(
      .width_p($bits(bp_commit_rec_s)),
      .els_p  (commit_els_p)
   ) commit_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (cm_enq_v),
      .ready_o(cm_ready),
      .data_i (cm_rec),
      .v_o    (cm_v),
      .data_o (cm_head),
      .yumi_i (deq)
   );

   for (genvar r = 0; r < rf_els_p; r++) begin : g_rf
      bsg_fifo_1r1w_small #(
         .width_p(data_width_p),
         .els_p  (rf_els_fifo_p)
      ) rf_fifo (
         .clk_i  (clk_i),
         .reset_i(reset_i),
         .v_i    (rf_v[r]),
         .ready_o(rf_ready[r]),
         .data_i (rf_d[r]),
         .v_o    (rf_head_v[r]),
         .data_o (rf_head_d[r]),
         .yumi_i (rf_deq[r])
      );
   end

   // Walk ports high to low so the lowest index wins a shared address.
   always_comb begin
      rf_v      = '0;
      collision = 1'b0;
      for (int r = 0; r < rf_els_p; r++) rf_d[r] = '0;
      for (int p = num_wb_p - 1; p >= 0; p--) begin
         if (wb_v_i[p] & ~reset_i) begin
            rf_v[wb_addr_i[p*rf_addr_w +: rf_addr_w]] = 1'b1;
            rf_d[wb_addr_i[p*rf_addr_w +: rf_addr_w]] =
               wb_data_i[p*data_width_p +: data_width_p];
         end
      end
      for (int p = 1; p < num_wb_p; p++) begin
         for (int q = 0; q < p; q++) begin
            if (wb_v_i[p] & wb_v_i[q] &
                (wb_addr_i[p*rf_addr_w +: rf_addr_w] ==
                 wb_addr_i[q*rf_addr_w +: rf_addr_w]))
               collision = ~reset_i;
         end
      end
   end

   assign rd_sel         = cm_head.rd_addr[rf_addr_w-1:0];
   assign match_v_o      = cm_v & (~cm_head.rd_w_v | rf_head_v[rd_sel]);
   assign match_data_o   = cm_head.rd_w_v ? rf_head_d[rd_sel] : '0;
   assign match_pc_o     = cm_head.pc[vaddr_width_p-1:0];
   assign match_instr_o  = cm_head.instr;
   assign match_rd_w_v_o = cm_head.rd_w_v;
   assign match_trap_o   = cm_head.trap;
   assign deq            = match_v_o & match_yumi_i;
   assign unused_head    = ^cm_head;

   always_comb begin
      rf_deq = '0;
      if (deq & cm_head.rd_w_v) rf_deq[rd_sel] = 1'b1;
   end

   always_comb begin
      stall_n = stall_cnt;
      if (~cm_v | deq)
         stall_n = '0;
      else if (~match_v_o && stall_cnt != stall_w'(timeout_p))
         stall_n = stall_cnt + 1'b1;

      err_n = err_o;
      if (collision)
         err_n[bp_err_collision_gp] = 1'b1;
      if (cm_enq_v & ~cm_ready & ~deq)
         err_n[bp_err_commit_overflow_gp] = 1'b1;
      if (|(rf_v & ~rf_ready & ~rf_deq))
         err_n[bp_err_rf_overflow_gp] = 1'b1;
      if (stall_n == stall_w'(timeout_p))
         err_n[bp_err_timeout_gp] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt   <= '0;
         err_o       <= '0;
         instr_cnt_o <= '0;
      end else begin
         stall_cnt <= stall_n;
         err_o     <= err_n;
         if (deq & ~cm_head.trap & ~&instr_cnt_o)
            instr_cnt_o <= instr_cnt_o + 64'd1;
      end
   end

endmodule

// File: tb/tb_bp_nonsynth_commit_matcher.sv
// Directed vector table plus hand sequences for overflow,
// timeout and reset corner cases of the commit matcher.
module tb_bp_nonsynth_commit_matcher;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        commit_v_i;
   logic [38:0] commit_pc_i;
   logic [31:0] commit_instr_i;
   logic        commit_rd_w_v_i;
   logic [5:0]  commit_rd_addr_i;
   logic        commit_trap_i;
   logic [1:0]  wb_v_i;
   logic [11:0] wb_addr_i;
   logic [127:0] wb_data_i;
   logic        match_v_o;
   logic        match_yumi_i;
   logic [38:0] match_pc_o;
   logic [31:0] match_instr_o;
   logic        match_rd_w_v_o;
   logic        match_trap_o;
   logic [63:0] match_data_o;
   logic [63:0] instr_cnt_o;
   logic [3:0]  err_o;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   bp_nonsynth_commit_matcher dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .commit_v_i      (commit_v_i),
      .commit_pc_i     (commit_pc_i),
      .commit_instr_i  (commit_instr_i),
      .commit_rd_w_v_i (commit_rd_w_v_i),
      .commit_rd_addr_i(commit_rd_addr_i),
      .commit_trap_i   (commit_trap_i),
      .wb_v_i          (wb_v_i),
      .wb_addr_i       (wb_addr_i),
      .wb_data_i       (wb_data_i),
      .match_v_o       (match_v_o),
      .match_yumi_i    (match_yumi_i),
      .match_pc_o      (match_pc_o),
      .match_instr_o   (match_instr_o),
      .match_rd_w_v_o  (match_rd_w_v_o),
      .match_trap_o    (match_trap_o),
      .match_data_o    (match_data_o),
      .instr_cnt_o     (instr_cnt_o),
      .err_o           (err_o)
   );

   typedef struct {
      logic        cv;
      logic [31:0] pc;
      logic        wv;
      logic [5:0]  rd;
      logic        tr;
      logic [1:0]  wbv;
      logic [5:0]  a0;
      logic [63:0] d0;
      logic [5:0]  a1;
      logic [63:0] d1;
      logic        y;
      logic        emv;
      logic [63:0] edata;
      logic [31:0] epc;
      logic        etrap;
      logic [63:0] ecnt;
      logic [3:0]  eerr;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] instr_of(logic [31:0] pc);
      return {pc[15:0], 16'h0013};
   endfunction

   function automatic vec_t mk(
      logic cv, logic [31:0] pc, logic wv, logic [5:0] rd, logic tr,
      logic [1:0] wbv, logic [5:0] a0, logic [63:0] d0,
      logic [5:0] a1, logic [63:0] d1, logic y,
      logic emv, logic [63:0] edata, logic [31:0] epc, logic etrap,
      logic [63:0] ecnt, logic [3:0] eerr);
      vec_t v;
      v.cv = cv; v.pc = pc; v.wv = wv; v.rd = rd; v.tr = tr;
      v.wbv = wbv; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.y = y; v.emv = emv; v.edata = edata; v.epc = epc;
      v.etrap = etrap; v.ecnt = ecnt; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(logic cv, logic [31:0] pc, logic wv,
                        logic [5:0] rd, logic tr, logic [1:0] wbv,
                        logic [5:0] a0, logic [63:0] d0,
                        logic [5:0] a1, logic [63:0] d1, logic y);
      commit_v_i       = cv;
      commit_pc_i      = 39'(pc);
      commit_instr_i   = instr_of(pc);
      commit_rd_w_v_i  = wv;
      commit_rd_addr_i = rd;
      commit_trap_i    = tr;
      wb_v_i           = wbv;
      wb_addr_i        = {a1, a0};
      wb_data_i        = {d1, d0};
      match_yumi_i     = y;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
   endtask

   // Drains with yumi held high; pc of each record must follow base+4*n.
   task automatic drain(input logic [31:0] base, output int n);
      n = 0;
      for (int k = 0; k < 40 && match_v_o; k++) begin
         idle();
         match_yumi_i = 1'b1;
         chk("drain_pc", 64'(match_pc_o), 64'(base + 32'(n * 4)));
         n++;
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      int n;
      idle();
      reset_i = 1'b1;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;

      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 0,4'h0));
      vq.push_back(mk(1,32'h80000000,1,5,0, 0,0,0,0,0, 0, 0,0,0,0, 0,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1, 0,0,0,0, 0,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 0,4'h0));
      vq.push_back(mk(0,0,0,0,0, 2'b01,5,64'hDEAD,0,0, 0, 0,0,0,0, 0,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,
                      1,64'hDEAD,32'h80000000,0, 0,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 1,4'h0));
      vq.push_back(mk(1,32'h80000004,0,0,1, 0,0,0,0,0, 0, 0,0,0,0, 1,4'h0));
      vq.push_back(mk(1,32'h80000008,0,0,0, 0,0,0,0,0, 1,
                      1,0,32'h80000004,1, 1,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,
                      1,0,32'h80000008,0, 1,4'h0));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 2,4'h0));
      vq.push_back(mk(0,0,0,0,0, 2'b11,7,64'h1,7,64'h2, 0,
                      0,0,0,0, 2,4'h0));
      vq.push_back(mk(1,32'h8000000C,1,7,0, 0,0,0,0,0, 0,
                      0,0,0,0, 2,4'h8));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,
                      1,64'h1,32'h8000000C,0, 2,4'h8));
      vq.push_back(mk(1,32'h80000010,1,7,0, 0,0,0,0,0, 0,
                      0,0,0,0, 3,4'h8));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 3,4'h8));
      vq.push_back(mk(0,0,0,0,0, 2'b10,0,0,7,64'h33, 0,
                      0,0,0,0, 3,4'h8));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,
                      1,64'h33,32'h80000010,0, 3,4'h8));
      vq.push_back(mk(0,0,0,0,0, 2'b11,3,64'hA,4,64'hB, 0,
                      0,0,0,0, 4,4'h8));
      vq.push_back(mk(1,32'h80000014,1,4,0, 0,0,0,0,0, 0,
                      0,0,0,0, 4,4'h8));
      vq.push_back(mk(1,32'h80000018,1,3,0, 0,0,0,0,0, 1,
                      1,64'hB,32'h80000014,0, 4,4'h8));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,
                      1,64'hA,32'h80000018,0, 5,4'h8));
      vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0, 6,4'h8));

      foreach (vq[i]) begin
         drive(vq[i].cv, vq[i].pc, vq[i].wv, vq[i].rd, vq[i].tr,
               vq[i].wbv, vq[i].a0, vq[i].d0, vq[i].a1, vq[i].d1,
               vq[i].y);
         #1;
         chk($sformatf("v%0d_match_v", i), 64'(match_v_o), 64'(vq[i].emv));
         if (vq[i].emv) begin
            chk($sformatf("v%0d_data", i), match_data_o, vq[i].edata);
            chk($sformatf("v%0d_pc", i), 64'(match_pc_o), 64'(vq[i].epc));
            chk($sformatf("v%0d_instr", i), 64'(match_instr_o),
                64'(instr_of(vq[i].epc)));
            chk($sformatf("v%0d_trap", i), 64'(match_trap_o),
                64'(vq[i].etrap));
         end
         chk($sformatf("v%0d_cnt", i), instr_cnt_o, vq[i].ecnt);
         chk($sformatf("v%0d_err", i), 64'(err_o), 64'(vq[i].eerr));
         @(negedge clk);
      end

      // Commit queue overflow: 17 pushes, one dropped.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
      end
      idle();
      chk("ovf_err", 64'(err_o), 64'h1);
      drain(0, n);
      chk("ovf_drain_n", 64'(n), 64'd16);
      chk("ovf_cnt", instr_cnt_o, 64'd16);

      // Full queue with same-cycle enqueue and dequeue.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
      end
      drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      idle();
      chk("full_bypass_err", 64'(err_o), 64'h0);
      drain(4, n);
      chk("full_bypass_n", 64'(n), 64'd16);

      // Timeout on a writeback that never arrives.
      do_reset();
      drive(1, 32'h200, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idle();
      repeat (1023) @(negedge clk);
      chk("to_err_1023", 64'(err_o), 64'h0);
      chk("to_mv_1023", 64'(match_v_o), 64'h0);
      @(negedge clk);
      chk("to_err_1024", 64'(err_o), 64'h4);
      chk("to_mv_1024", 64'(match_v_o), 64'h0);
      drive(0, 0, 0, 0, 0, 2'b01, 9, 64'h99, 0, 0, 0);
      @(negedge clk);
      idle();
      chk("to_late_mv", 64'(match_v_o), 64'h1);
      chk("to_late_data", match_data_o, 64'h99);
      chk("to_sticky", 64'(err_o), 64'h4);

      // Register queue overflow: nine writes into an 8-deep queue.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 0, 0, 0, 2'b01, 2, 64'(i + 1), 0, 0, 0);
         @(negedge clk);
      end
      drive(1, 32'h300, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idle();
      chk("rfovf_err", 64'(err_o), 64'h2);
      chk("rfovf_data", match_data_o, 64'h1);

      // Reset with records queued; inputs during reset are ignored.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'(32'h400 + i * 4), 0, 0, 0, 2'b01, 5, 64'h55, 0, 0, 0);
         @(negedge clk);
      end
      idle();
      chk("rst_pre_mv", 64'(match_v_o), 64'h1);
      drive(1, 32'h500, 0, 0, 0, 2'b11, 5, 64'h66, 5, 64'h77, 1);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      idle();
      chk("rst_mv", 64'(match_v_o), 64'h0);
      chk("rst_cnt", instr_cnt_o, 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      drive(1, 32'h600, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("rst_stale_mv", 64'(match_v_o), 64'h0);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
